dmem_port_arbiter: RTL and testbench

- Parametrised N-master front end for one shared single-port synchronous data memory (dmem syncram, clocked on ~clock).
- Lets the processor, a debug/program loader and future peripherals share dmem without changes to the processor's memory interface.
- Provides round-robin arbitration, per-master read-return tracking across a configurable memory read latency, and a lock mode for atomic multi-access sequences.

---
 rtl/dmem_arb_pkg.sv | 21 ++
 rtl/dmem_port_arbiter_rr_arbiter.sv | 32 +++
 rtl/dmem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the dmem port arbiter: lock-state encoding,
// master-id width function and the read-return pipeline entry.
package dmem_arb_pkg;

  localparam int MAX_ID_W = 3;

  typedef enum logic [0:0] {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } ret_entry_t;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping
// modulo N. Holding ptr at 0 turns it into a lowest-index-wins priority encoder.
module rr_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int N   = 2,
  parameter int IDW = id_w(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_idx
);

  int   idx_s;
  logic found_s;

  // Scan downward so the last hit wins: that is the first requester at or after ptr.
  always_comb begin
    idx_s   = 0;
    found_s = 1'b0;
    gnt_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx_s   = int'(ptr) + k;
      idx_s   = (idx_s >= N) ? idx_s - N : idx_s;
      gnt_idx = req[IDW'(idx_s)] ? IDW'(idx_s) : gnt_idx;
      found_s = found_s | req[IDW'(idx_s)];
    end
    gnt = found_s ? ({{(N-1){1'b0}}, 1'b1} << gnt_idx) : '0;
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// N-master front end for one shared single-port dmem (read latency RD_LATENCY).
// Build option: define DMEM_ARB_FIXED_PRIO_EN for fixed priority (master 0 first).
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 12,
  parameter int NUM_MASTERS = 2,
  parameter int RD_LATENCY  = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_MASTERS-1:0]        req,
  input  logic [NUM_MASTERS-1:0]        we,
  input  logic [NUM_MASTERS-1:0]        lock,
  input  logic [NUM_MASTERS*ADDR_W-1:0] addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] wdata,
  output logic [NUM_MASTERS-1:0]        gnt,
  output logic [NUM_MASTERS-1:0]        rvalid,
  output logic [DATA_W-1:0]             rdata,
  output logic [ADDR_W-1:0]             mem_address,
  output logic [DATA_W-1:0]             mem_data,
  output logic                          mem_wren,
  input  logic [DATA_W-1:0]             mem_q
);

  localparam int ID_W = id_w(NUM_MASTERS);
  localparam logic [NUM_MASTERS-1:0] ONE_HOT0 = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

  lock_state_e            lock_state_q, lock_state_d;
  logic [ID_W-1:0]        owner_q, owner_d;
  logic [ID_W-1:0]        ptr_q, ptr_d;
  ret_entry_t             ret_q [RD_LATENCY];
  ret_entry_t             ret_d [RD_LATENCY];

  logic [NUM_MASTERS-1:0] rr_gnt_s, gnt_s;
  logic [ID_W-1:0]        rr_idx_s, gidx_s;
  logic                   accept_s;
  logic [ADDR_W-1:0]      addr_a  [NUM_MASTERS];
  logic [DATA_W-1:0]      wdata_a [NUM_MASTERS];

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
    assign addr_a[i]  = addr[i*ADDR_W +: ADDR_W];
    assign wdata_a[i] = wdata[i*DATA_W +: DATA_W];
  end

  rr_arbiter #(
    .N   (NUM_MASTERS),
    .IDW (ID_W)
  ) u_rr (
    .req     (req),
    .ptr     (ptr_q),
    .gnt     (rr_gnt_s),
    .gnt_idx (rr_idx_s)
  );

  // Grant selection: arbiter result when unlocked, owner only while locked.
  always_comb begin
    gnt_s  = '0;
    gidx_s = '0;
    case (lock_state_q)
      UNLOCKED: begin
        gnt_s  = rr_gnt_s;
        gidx_s = rr_idx_s;
      end
      LOCKED: begin
        gnt_s  = req[owner_q] ? (ONE_HOT0 << owner_q) : '0;
        gidx_s = owner_q;
      end
      default: begin
        gnt_s  = '0;
        gidx_s = '0;
      end
    endcase
    accept_s = |gnt_s;
  end

  // Output drive; reset forces an idle memory port, idle port shows master 0.
  always_comb begin
    gnt         = reset ? '0 : gnt_s;
    mem_address = reset ? '0 : (accept_s ? addr_a[gidx_s] : addr_a[0]);
    mem_data    = reset ? '0 : (accept_s ? wdata_a[gidx_s] : wdata_a[0]);
    mem_wren    = reset ? 1'b0 : (accept_s & we[gidx_s]);
    rvalid      = ret_q[RD_LATENCY-1].valid ? (ONE_HOT0 << ret_q[RD_LATENCY-1].id) : '0;
    rdata       = mem_q;
  end

  // Next state for pointer, lock FSM and read-return pipeline.
  always_comb begin
    lock_state_d = lock_state_q;
    owner_d      = owner_q;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    ptr_d = '0;
`else
    ptr_d = accept_s ? ((gidx_s == ID_W'(NUM_MASTERS - 1)) ? '0 : gidx_s + 1'b1) : ptr_q;
`endif
    case (lock_state_q)
      UNLOCKED: begin
        if (accept_s && lock[gidx_s]) begin
          lock_state_d = LOCKED;
          owner_d      = gidx_s;
        end else begin
          lock_state_d = UNLOCKED;
        end
      end
      LOCKED: begin
        if (accept_s && !lock[gidx_s]) begin
          lock_state_d = UNLOCKED;
        end else begin
          lock_state_d = LOCKED;
        end
      end
      default: lock_state_d = UNLOCKED;
    endcase
    for (int i = 0; i < RD_LATENCY; i++) begin
      ret_d[i] = '0;
    end
    ret_d[0].valid = accept_s & ~we[gidx_s];
    ret_d[0].id    = MAX_ID_W'(gidx_s);
    for (int i = 1; i < RD_LATENCY; i++) begin
      ret_d[i] = ret_q[i-1];
    end
  end

  // State registers; reset drops outstanding reads and releases any lock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lock_state_q <= UNLOCKED;
      owner_q      <= '0;
      ptr_q        <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        ret_q[i] <= '0;
      end
    end else begin
      lock_state_q <= lock_state_d;
      owner_q      <= owner_d;
      ptr_q        <= ptr_d;
      for (int i = 0; i < RD_LATENCY; i++) begin
        ret_q[i] <= ret_d[i];
      end
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: instance A (2 masters, latency 1) and
// instance B (3 masters, latency 4), each with a negedge-clocked memory model.
module tb_dmem_port_arbiter;

  logic clock;
  logic reset;

  logic [1:0]  a_req, a_we, a_lock, a_gnt, a_rvalid;
  logic [23:0] a_addr;
  logic [63:0] a_wdata;
  logic [31:0] a_rdata, a_mem_data, a_mem_q;
  logic [11:0] a_mem_address;
  logic        a_mem_wren;
  logic [31:0] a_mem [4096];

  logic [2:0]  b_req, b_we, b_lock, b_gnt, b_rvalid;
  logic [35:0] b_addr;
  logic [95:0] b_wdata;
  logic [31:0] b_rdata, b_mem_data, b_mem_q;
  logic [11:0] b_mem_address;
  logic        b_mem_wren;
  logic [31:0] b_mem [4096];
  logic [31:0] b_stg [4];

  logic [1:0]  a_exp [4];
  logic [2:0]  b_exp [4];

  int tests_run;
  int tests_failed;

  dmem_port_arbiter #(
    .DATA_W(32), .ADDR_W(12), .NUM_MASTERS(2), .RD_LATENCY(1)
  ) u_dut_a (
    .clock(clock), .reset(reset), .req(a_req), .we(a_we), .lock(a_lock),
    .addr(a_addr), .wdata(a_wdata), .gnt(a_gnt), .rvalid(a_rvalid), .rdata(a_rdata),
    .mem_address(a_mem_address), .mem_data(a_mem_data), .mem_wren(a_mem_wren),
    .mem_q(a_mem_q)
  );

  dmem_port_arbiter #(
    .DATA_W(32), .ADDR_W(12), .NUM_MASTERS(3), .RD_LATENCY(4)
  ) u_dut_b (
    .clock(clock), .reset(reset), .req(b_req), .we(b_we), .lock(b_lock),
    .addr(b_addr), .wdata(b_wdata), .gnt(b_gnt), .rvalid(b_rvalid), .rdata(b_rdata),
    .mem_address(b_mem_address), .mem_data(b_mem_data), .mem_wren(b_mem_wren),
    .mem_q(b_mem_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // syncram clocked on the falling edge; B adds three more stages of read delay
  always @(negedge clock) begin
    if (a_mem_wren) a_mem[a_mem_address] <= a_mem_data;
    a_mem_q <= a_mem[a_mem_address];
    if (b_mem_wren) b_mem[b_mem_address] <= b_mem_data;
    b_stg[0] <= b_mem[b_mem_address];
    for (int j = 1; j < 4; j++) b_stg[j] <= b_stg[j-1];
  end
  assign b_mem_q = b_stg[3];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] a_data(input logic [1:0] g);
    return (g == 2'b01) ? 32'hDEADBEEF : 32'h12345678;
  endfunction

  function automatic logic [31:0] b_data(input logic [2:0] g);
    return (g == 3'b010) ? 32'hBBBB0002 : 32'hAAAA0001;
  endfunction

  initial begin
    tests_run    = 0;
    tests_failed = 0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    a_exp = '{2'b01, 2'b01, 2'b01, 2'b01};
    b_exp = '{3'b001, 3'b001, 3'b001, 3'b001};
`else
    a_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
    b_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
`endif
    reset = 1'b1;
    a_req = 2'b00; a_we = 2'b00; a_lock = 2'b00; a_addr = 24'h0; a_wdata = 64'h0;
    b_req = 3'b000; b_we = 3'b000; b_lock = 3'b000; b_addr = 36'h0; b_wdata = 96'h0;

    // reset: requests present, outputs must stay idle
    #2;
    a_req = 2'b11; a_we = 2'b11; a_addr = {12'h5A5, 12'h3C3}; a_wdata = 64'h1111_2222_3333_4444;
    #1;
    check_eq("rst_gnt", a_gnt, 2'b00);
    check_eq("rst_wren", a_mem_wren, 1'b0);
    check_eq("rst_addr", a_mem_address, 12'h000);
    check_eq("rst_data", a_mem_data, 32'h0);
    a_req = 2'b00; a_we = 2'b00; a_addr = 24'h0; a_wdata = 64'h0;
    tick();
    check_eq("rst_rvalid_a", a_rvalid, 2'b00);
    check_eq("rst_rvalid_b", b_rvalid, 3'b000);
    reset = 1'b0;

    // A: master 0 writes then reads the same word
    a_req = 2'b01; a_we = 2'b01; a_addr[11:0] = 12'h010; a_wdata[31:0] = 32'hDEADBEEF;
    #1;
    check_eq("a_wr_gnt", a_gnt, 2'b01);
    check_eq("a_wr_wren", a_mem_wren, 1'b1);
    check_eq("a_wr_addr", a_mem_address, 12'h010);
    check_eq("a_wr_data", a_mem_data, 32'hDEADBEEF);
    tick();
    check_eq("a_wr_noresp", a_rvalid, 2'b00);
    a_we = 2'b00;
    #1;
    check_eq("a_rd_gnt", a_gnt, 2'b01);
    check_eq("a_rd_wren", a_mem_wren, 1'b0);
    tick();
    check_eq("a_rd_rvalid", a_rvalid, 2'b01);
    check_eq("a_rd_rdata", a_rdata, 32'hDEADBEEF);

    // A: master 1 writes alone (moves pointer back to 0)
    a_req = 2'b10; a_we = 2'b10; a_addr[23:12] = 12'h020; a_wdata[63:32] = 32'h12345678;
    #1;
    check_eq("a_m1_gnt", a_gnt, 2'b10);
    check_eq("a_m1_addr", a_mem_address, 12'h020);
    check_eq("a_m1_data", a_mem_data, 32'h12345678);
    tick();
    check_eq("a_m1_noresp", a_rvalid, 2'b00);

    // A: both masters read every cycle
    a_req = 2'b11; a_we = 2'b00;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        check_eq("a_rr_rvalid", a_rvalid, a_exp[i-1]);
        check_eq("a_rr_rdata", a_rdata, a_data(a_exp[i-1]));
      end
      #1;
      check_eq("a_rr_gnt", a_gnt, a_exp[i]);
      tick();
    end
    check_eq("a_rr_rvalid_last", a_rvalid, a_exp[3]);
    check_eq("a_rr_rdata_last", a_rdata, a_data(a_exp[3]));

    // A: master 1 takes the lock, master 0 waits until it is released
    a_req = 2'b10; a_we = 2'b10; a_lock = 2'b10; a_addr[23:12] = 12'h030;
    #1;
    check_eq("a_lk0_gnt", a_gnt, 2'b10);
    tick();
    a_req = 2'b11; a_we = 2'b11; a_addr = {12'h031, 12'h040}; a_wdata = {32'h31, 32'h40};
    #1;
    check_eq("a_lk1_gnt", a_gnt, 2'b10);
    check_eq("a_lk1_addr", a_mem_address, 12'h031);
    tick();
    a_req = 2'b01;
    #1;
    check_eq("a_lk_idle_gnt", a_gnt, 2'b00);
    check_eq("a_lk_idle_wren", a_mem_wren, 1'b0);
    tick();
    a_req = 2'b11; a_addr[23:12] = 12'h032;
    #1;
    check_eq("a_lk3_gnt", a_gnt, 2'b10);
    tick();
    a_lock = 2'b00; a_addr[23:12] = 12'h033;
    #1;
    check_eq("a_unlk_gnt", a_gnt, 2'b10);
    tick();
    #1;
    check_eq("a_after_gnt", a_gnt, 2'b01);
    check_eq("a_after_addr", a_mem_address, 12'h040);
    tick();
    a_req = 2'b00; a_we = 2'b00;

    // B: master 2 preloads two words, leaving the pointer wrapped to 0
    b_req = 3'b100; b_we = 3'b100; b_addr[35:24] = 12'h001; b_wdata[95:64] = 32'hAAAA0001;
    #1;
    check_eq("b_pre0_gnt", b_gnt, 3'b100);
    tick();
    b_addr[35:24] = 12'h002; b_wdata[95:64] = 32'hBBBB0002;
    #1;
    check_eq("b_pre1_gnt", b_gnt, 3'b100);
    tick();

    // B: three masters read for four cycles, returns four cycles later in order
    b_we = 3'b000; b_addr = {12'h001, 12'h002, 12'h001};
    for (int c = 0; c < 8; c++) begin
      if (c >= 4) begin
        check_eq("b_lat_rvalid", b_rvalid, b_exp[c-4]);
        check_eq("b_lat_rdata", b_rdata, b_data(b_exp[c-4]));
        b_req = 3'b000;
        #1;
        check_eq("b_idle_gnt", b_gnt, 3'b000);
      end else begin
        check_eq("b_early_rvalid", b_rvalid, 3'b000);
        b_req = 3'b111;
        #1;
        check_eq("b_rr_gnt", b_gnt, b_exp[c]);
      end
      tick();
    end
    check_eq("b_drain_rvalid", b_rvalid, 3'b000);

    // reset mid-read on B while A holds a lock
    a_req = 2'b10; a_we = 2'b10; a_lock = 2'b10; a_addr[23:12] = 12'h050;
    b_req = 3'b001; b_we = 3'b000; b_addr[11:0] = 12'h001;
    #1;
    check_eq("rs_a_gnt", a_gnt, 2'b10);
    check_eq("rs_b_gnt", b_gnt, 3'b001);
    tick();
    a_req = 2'b00; a_we = 2'b00; a_lock = 2'b00; b_req = 3'b000;
    reset = 1'b1;
    #1;
    check_eq("rs_b_rvalid", b_rvalid, 3'b000);
    check_eq("rs_b_gnt_idle", b_gnt, 3'b000);
    check_eq("rs_b_wren", b_mem_wren, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check_eq("rs_dropped_rvalid", b_rvalid, 3'b000);
      tick();
    end
    a_req = 2'b11; b_req = 3'b010;
    #1;
    check_eq("rs_b_m1_gnt", b_gnt, 3'b010);
    check_eq("rs_a_unlocked_gnt", a_gnt, 2'b01);
    tick();
    a_req = 2'b00; b_req = 3'b000;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end of the test sequence");
    $fatal(1);
  end

endmodule
